pcs_drp_arbiter: RTL and testbench

- Shares one transceiver DRP port among NUM_CH PCS/PMA channel cores. Each core uses its own drp_req/drp_gnt handshake.
- Successor to the single-channel tie-off, where drp_req looped straight to drp_gnt. Adds round-robin arbitration, registered DRP forwarding, multiple transactions per grant and a watchdog timeout with error reporting.
- Sits between N ten-gig PCS/PMA instances and the shared GT/QPLL DRP, clocked by coreclk (the same clock used as dclk).

---
 rtl/pcs_drp_arbiter_pkg.sv | 27 ++
 rtl/pcs_drp_arbiter_if.sv | 24 ++
 rtl/pcs_drp_arbiter_rr.sv | 33 +++
 rtl/pcs_drp_arbiter.sv | 132 +++++++++++++
 tb/tb_pcs_drp_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_drp_arbiter_pkg.sv
// Shared types and helpers for the PCS DRP arbiter slice.
package pcs_drp_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANTED  = 2'd1,
    WAIT_RDY = 2'd2
  } drp_state_e;

  // Read data handed back to a channel whose access was aborted
  localparam logic [15:0] DEFAULT_TO_DATA = 16'hDEAD;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of an index into n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcs_drp_arbiter_if.sv
// Shared transceiver DRP bus: the arbiter drives it as master, the GT/QPLL is the slave.
interface pcs_drp_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              m_den;
  logic              m_dwe;
  logic [ADDR_W-1:0] m_daddr;
  logic [DATA_W-1:0] m_di;
  logic              m_drdy;
  logic [DATA_W-1:0] m_drpdo;

  modport master (
    output m_den, m_dwe, m_daddr, m_di,
    input  m_drdy, m_drpdo
  );

  modport slave (
    input  m_den, m_dwe, m_daddr, m_di,
    output m_drdy, m_drpdo
  );

endinterface

// File: rtl/pcs_drp_arbiter_rr.sv
// Combinational round-robin pick: first requester after the last owner, with wrap.
module rr_arbiter_prio
  import pcs_drp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan last+1 .. last+NUM_CH so the previous owner is checked last
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand     = (int'(last) + i) % NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pcs_drp_arbiter.sv
// Shares one transceiver DRP port among NUM_CH PCS/PMA channels with
// round-robin grants, registered forwarding and a completion watchdog.
module pcs_drp_arbiter
  import pcs_drp_pkg::*;
#(
  parameter int                NUM_CH  = 4,
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter int                TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] TO_DATA = DATA_W'(DEFAULT_TO_DATA),
  parameter int                OWNER_W = idx_width(NUM_CH)
) (
  input  logic                     coreclk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_gnt,
  input  logic [NUM_CH-1:0]        ch_den,
  input  logic [NUM_CH-1:0]        ch_dwe,
  input  logic [NUM_CH*ADDR_W-1:0] ch_daddr,
  input  logic [NUM_CH*DATA_W-1:0] ch_di,
  output logic [NUM_CH-1:0]        ch_drdy,
  output logic [DATA_W-1:0]        ch_drpdo,
  pcs_drp_arbiter_if.master        drp,
  output logic                     timeout_o,
  output logic                     proto_err_o,
  output logic [OWNER_W-1:0]       owner_o
);

  // One extra bit so TIMEOUT itself is representable and the count can saturate
  localparam int               CNT_W    = clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  drp_state_e         state;
  logic [CNT_W-1:0]   cnt;

  logic               pick_valid;
  logic [OWNER_W-1:0] pick_idx;
  logic [NUM_CH-1:0]  pick_onehot;
  logic [NUM_CH-1:0]  owner_onehot;

  logic               own_req;
  logic               own_den;
  logic               own_dwe;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_di;

  rr_arbiter_prio #(
    .NUM_CH (NUM_CH),
    .IDX_W  (OWNER_W)
  ) u_rr (
    .req   (ch_req),
    .last  (owner_o),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the current owner's request lines and bus slice
  always_comb begin
    own_req      = ch_req[owner_o];
    own_den      = ch_den[owner_o];
    own_dwe      = ch_dwe[owner_o];
    own_addr     = ADDR_W'(ch_daddr >> (int'(owner_o) * ADDR_W));
    own_di       = DATA_W'(ch_di >> (int'(owner_o) * DATA_W));
    pick_onehot  = NUM_CH'(1) << pick_idx;
    owner_onehot = NUM_CH'(1) << owner_o;
  end

  // Arbitration FSM with registered grant, DRP forwarding and watchdog
  always_ff @(posedge coreclk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_o     <= OWNER_W'(NUM_CH - 1);
      ch_gnt      <= '0;
      ch_drdy     <= '0;
      ch_drpdo    <= '0;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
      drp.m_den   <= 1'b0;
      drp.m_dwe   <= 1'b0;
      drp.m_daddr <= '0;
      drp.m_di    <= '0;
    end else begin
      drp.m_den   <= 1'b0;
      ch_drdy     <= '0;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner_o <= pick_idx;
            ch_gnt  <= pick_onehot;
            state   <= GRANTED;
          end
        end
        GRANTED: begin
          if (!own_req) begin
            ch_gnt <= '0;
            state  <= IDLE;
          end else if (own_den) begin
            drp.m_den   <= 1'b1;
            drp.m_dwe   <= own_dwe;
            drp.m_daddr <= own_addr;
            drp.m_di    <= own_di;
            cnt         <= '0;
            state       <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          if (own_den) proto_err_o <= 1'b1;
          if (drp.m_drdy) begin
            ch_drdy  <= owner_onehot;
            ch_drpdo <= drp.m_drpdo;
            state    <= GRANTED;
          end else if (cnt == CNT_LAST) begin
            ch_drdy   <= owner_onehot;
            ch_drpdo  <= TO_DATA;
            timeout_o <= 1'b1;
            state     <= GRANTED;
          end
        end
        default: begin
          ch_gnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_drp_arbiter.sv
// Directed bench for pcs_drp_arbiter with a scoreboard of expected DRP
// transactions and channel completions.
module tb_pcs_drp_arbiter;
  import pcs_drp_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic                     coreclk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_den;
  logic [NUM_CH-1:0]        ch_dwe;
  logic [NUM_CH*ADDR_W-1:0] ch_daddr;
  logic [NUM_CH*DATA_W-1:0] ch_di;
  logic [NUM_CH-1:0]        ch_drdy;
  logic [DATA_W-1:0]        ch_drpdo;
  logic                     timeout_o;
  logic                     proto_err_o;
  logic [1:0]               owner_o;

  pcs_drp_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) drp_if ();

  pcs_drp_arbiter #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .TO_DATA (16'hDEAD)
  ) dut (
    .coreclk     (coreclk),
    .rst_n       (rst_n),
    .ch_req      (ch_req),
    .ch_gnt      (ch_gnt),
    .ch_den      (ch_den),
    .ch_dwe      (ch_dwe),
    .ch_daddr    (ch_daddr),
    .ch_di       (ch_di),
    .ch_drdy     (ch_drdy),
    .ch_drpdo    (ch_drpdo),
    .drp         (drp_if),
    .timeout_o   (timeout_o),
    .proto_err_o (proto_err_o),
    .owner_o     (owner_o)
  );

  always #5 coreclk = ~coreclk;

  typedef struct {
    logic        dwe;
    logic [15:0] addr;
    logic [15:0] di;
  } txn_t;

  typedef struct {
    int          ch;
    logic [15:0] data;
    logic        to;
  } cpl_t;

  txn_t txn_q[$];
  cpl_t cpl_q[$];
  txn_t mon_t;
  cpl_t mon_c;
  int   n_evals = 0;
  int   n_fails = 0;
  bit   mon_en  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_evals++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge coreclk);
  endtask

  // Owner strobes ch_den for one cycle; the matching m_den is expected next cycle
  task automatic applyStimulus(input int ch, input logic we, input logic [15:0] addr,
                               input logic [15:0] di);
    txn_t t;
    logic [1:0] c;
    c = 2'(ch);
    t.dwe = we;
    t.addr = addr;
    t.di = di;
    txn_q.push_back(t);
    ch_den = '0;
    ch_den[c] = 1'b1;
    ch_dwe[c] = we;
    ch_daddr[ch*ADDR_W +: ADDR_W] = addr;
    ch_di[ch*DATA_W +: DATA_W] = di;
    @(negedge coreclk);
    ch_den = '0;
  endtask

  // GT answers with one m_drdy; the channel completion is expected next cycle
  task automatic completeAccess(input int ch, input logic [15:0] rdata);
    cpl_t c;
    c.ch = ch;
    c.data = rdata;
    c.to = 1'b0;
    cpl_q.push_back(c);
    drp_if.m_drdy = 1'b1;
    drp_if.m_drpdo = rdata;
    @(negedge coreclk);
    drp_if.m_drdy = 1'b0;
  endtask

  task automatic doAccess(input int ch, input logic we, input logic [15:0] addr,
                          input logic [15:0] di, input logic [15:0] rdata);
    applyStimulus(ch, we, addr, di);
    completeAccess(ch, rdata);
  endtask

  // Scoreboard monitor: every m_den and ch_drdy must match the oldest expectation
  always @(negedge coreclk) begin
    if (mon_en) begin
      checkOutput("gnt_onehot0", 32'($onehot0(ch_gnt)), 32'h1);
      if (drp_if.m_den === 1'b1) begin
        if (txn_q.size() == 0) begin
          checkOutput("m_den_unexpected", 32'(drp_if.m_den), 32'h0);
        end else begin
          mon_t = txn_q.pop_front();
          checkOutput("m_dwe", 32'(drp_if.m_dwe), 32'(mon_t.dwe));
          checkOutput("m_daddr", 32'(drp_if.m_daddr), 32'(mon_t.addr));
          checkOutput("m_di", 32'(drp_if.m_di), 32'(mon_t.di));
        end
      end
      if (ch_drdy !== '0) begin
        if (cpl_q.size() == 0) begin
          checkOutput("ch_drdy_unexpected", 32'(ch_drdy), 32'h0);
        end else begin
          mon_c = cpl_q.pop_front();
          checkOutput("ch_drdy", 32'(ch_drdy), 32'(1) << mon_c.ch);
          checkOutput("ch_drpdo", 32'(ch_drpdo), 32'(mon_c.data));
          checkOutput("timeout_flag", 32'(timeout_o), 32'(mon_c.to));
        end
      end else begin
        checkOutput("timeout_without_drdy", 32'(timeout_o), 32'h0);
      end
    end
  end

  initial begin
    cpl_t tc;
    rst_n          = 1'b0;
    ch_req         = '0;
    ch_den         = '0;
    ch_dwe         = '0;
    ch_daddr       = '0;
    ch_di          = '0;
    drp_if.m_drdy  = 1'b0;
    drp_if.m_drpdo = '0;

    // Reset state
    waitCycles(2);
    checkOutput("rst_gnt", 32'(ch_gnt), 32'h0);
    checkOutput("rst_drdy", 32'(ch_drdy), 32'h0);
    checkOutput("rst_m_den", 32'(drp_if.m_den), 32'h0);
    checkOutput("rst_m_daddr", 32'(drp_if.m_daddr), 32'h0);
    checkOutput("rst_drpdo", 32'(ch_drpdo), 32'h0);
    checkOutput("rst_timeout", 32'(timeout_o), 32'h0);
    checkOutput("rst_owner", 32'(owner_o), 32'h3);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single read on channel 0
    ch_req = 4'b0001;
    waitCycles(1);
    checkOutput("single_gnt", 32'(ch_gnt), 32'h1);
    applyStimulus(0, 1'b0, 16'h0044, 16'h0000);
    checkOutput("single_m_den", 32'(drp_if.m_den), 32'h1);
    checkOutput("single_m_daddr", 32'(drp_if.m_daddr), 32'h0044);
    completeAccess(0, 16'h1234);
    checkOutput("single_drdy", 32'(ch_drdy), 32'h1);
    checkOutput("single_drpdo", 32'(ch_drpdo), 32'h1234);
    waitCycles(1);
    checkOutput("drdy_one_cycle", 32'(ch_drdy), 32'h0);
    checkOutput("drpdo_hold", 32'(ch_drpdo), 32'h1234);
    checkOutput("m_daddr_hold", 32'(drp_if.m_daddr), 32'h0044);
    ch_req = 4'b0000;
    waitCycles(1);
    checkOutput("single_release", 32'(ch_gnt), 32'h0);

    // Short reset so the rotation restarts from channel 0
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("owner_after_reset", 32'(owner_o), 32'h3);
    rst_n = 1'b1;

    // Round robin with all four requesting
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % NUM_CH;
      waitCycles(1);
      checkOutput("rr_gnt", 32'(ch_gnt), 32'(1) << e);
      checkOutput("rr_owner", 32'(owner_o), 32'(e));
      doAccess(e, 1'(k % 2), 16'(16'h0100 + k), 16'(16'h1100 + k), 16'(16'hA000 + k));
      ch_req[2'(e)] = 1'b0;
      waitCycles(1);
      checkOutput("rr_idle_gap", 32'(ch_gnt), 32'h0);
      ch_req[2'(e)] = 1'b1;
    end
    ch_req = 4'b0000;
    waitCycles(1);

    // Watchdog on channel 1: no m_drdy ever arrives
    ch_req = 4'b0010;
    waitCycles(1);
    checkOutput("to_gnt", 32'(ch_gnt), 32'h2);
    tc.ch = 1;
    tc.data = 16'hDEAD;
    tc.to = 1'b1;
    cpl_q.push_back(tc);
    applyStimulus(1, 1'b0, 16'h0200, 16'h0000);
    waitCycles(7);
    checkOutput("to_not_early", 32'(timeout_o), 32'h0);
    checkOutput("to_drdy_not_early", 32'(ch_drdy), 32'h0);
    waitCycles(1);
    checkOutput("to_pulse", 32'(timeout_o), 32'h1);
    checkOutput("to_drdy", 32'(ch_drdy), 32'h2);
    checkOutput("to_data", 32'(ch_drpdo), 32'hDEAD);
    checkOutput("to_gnt_held", 32'(ch_gnt), 32'h2);
    doAccess(1, 1'b0, 16'h0201, 16'h0000, 16'h5555);
    checkOutput("after_to_data", 32'(ch_drpdo), 32'h5555);
    ch_req = 4'b0000;
    waitCycles(1);
    checkOutput("to_release", 32'(ch_gnt), 32'h0);

    // Write then read under a single grant on channel 2
    ch_req = 4'b0100;
    waitCycles(1);
    checkOutput("b2b_gnt", 32'(ch_gnt), 32'h4);
    doAccess(2, 1'b1, 16'h0300, 16'hBEEF, 16'h0000);
    checkOutput("b2b_gnt_mid", 32'(ch_gnt), 32'h4);
    checkOutput("b2b_m_di_hold", 32'(drp_if.m_di), 32'hBEEF);
    checkOutput("b2b_m_dwe_hold", 32'(drp_if.m_dwe), 32'h1);
    doAccess(2, 1'b0, 16'h0301, 16'h0000, 16'hC0DE);
    checkOutput("b2b_gnt_end", 32'(ch_gnt), 32'h4);
    checkOutput("b2b_rdata", 32'(ch_drpdo), 32'hC0DE);

    // Owner strobes again while its access is outstanding
    applyStimulus(2, 1'b0, 16'h0400, 16'h0000);
    ch_den = 4'b0100;
    ch_daddr[2*ADDR_W +: ADDR_W] = 16'h0500;
    waitCycles(1);
    ch_den = '0;
    checkOutput("proto_err_pulse", 32'(proto_err_o), 32'h1);
    completeAccess(2, 16'h7777);
    checkOutput("proto_err_once", 32'(proto_err_o), 32'h0);

    // Non-owner strobe while channel 2 holds the grant
    ch_den = 4'b0001;
    ch_daddr[0 +: ADDR_W] = 16'h0600;
    waitCycles(1);
    ch_den = '0;
    checkOutput("nonowner_no_m_den", 32'(drp_if.m_den), 32'h0);
    checkOutput("nonowner_no_err", 32'(proto_err_o), 32'h0);

    // Request dropped mid-access: completion still delivered, then release
    applyStimulus(2, 1'b0, 16'h0700, 16'h0000);
    ch_req = 4'b0000;
    waitCycles(1);
    checkOutput("drop_gnt_held", 32'(ch_gnt), 32'h4);
    completeAccess(2, 16'h8888);
    checkOutput("drop_drdy", 32'(ch_drdy), 32'h4);
    checkOutput("drop_gnt_at_cpl", 32'(ch_gnt), 32'h4);
    waitCycles(1);
    checkOutput("drop_release", 32'(ch_gnt), 32'h0);

    // Reset during WAIT_RDY, then a stale m_drdy
    ch_req = 4'b1001;
    waitCycles(1);
    checkOutput("rstmid_gnt", 32'(ch_gnt), 32'h8);
    applyStimulus(3, 1'b0, 16'h0800, 16'h0000);
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("rstmid_gnt_clr", 32'(ch_gnt), 32'h0);
    checkOutput("rstmid_m_den", 32'(drp_if.m_den), 32'h0);
    checkOutput("rstmid_m_daddr", 32'(drp_if.m_daddr), 32'h0);
    checkOutput("rstmid_drpdo", 32'(ch_drpdo), 32'h0);
    checkOutput("rstmid_owner", 32'(owner_o), 32'h3);
    rst_n = 1'b1;
    drp_if.m_drdy = 1'b1;
    drp_if.m_drpdo = 16'h9999;
    waitCycles(1);
    drp_if.m_drdy = 1'b0;
    checkOutput("stale_no_drdy", 32'(ch_drdy), 32'h0);
    checkOutput("rstmid_first_gnt", 32'(ch_gnt), 32'h1);
    ch_req = 4'b0000;
    waitCycles(2);
    checkOutput("txn_q_drained", 32'(txn_q.size()), 32'h0);
    checkOutput("cpl_q_drained", 32'(cpl_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_evals, n_fails);
    $finish;
  end

endmodule
